// File: rtl/cu_pkg.sv
// Shared definitions for the processor control unit.
// Holds opcodes, the FSM state encoding and the accumulator source select codes.
package cu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // INIT must stay at zero so a cleared register decodes to "no strobes".
  typedef enum logic [3:0] {
    INIT    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    LOAD_X  = 4'd3,
    STORE_X = 4'd4,
    ADD_X   = 4'd5,
    SUB_X   = 4'd6,
    IN_WAIT = 4'd7,
    IN_LOAD = 4'd8,
    IN_REL  = 4'd9,
    JUMP    = 4'd10,
    HALT    = 4'd11
  } state_t;

  localparam logic [1:0] ASEL_ALU  = 2'd0;
  localparam logic [1:0] ASEL_IN   = 2'd1;
  localparam logic [1:0] ASEL_RAM  = 2'd2;
  localparam logic [1:0] ASEL_ZERO = 2'd3;

endpackage

// File: rtl/control_unit.sv
// Fetch/decode/execute controller for the 8-bit accumulator datapath.
// Strobes are a pure decode of the state register; the fetch counter is inline.
module control_unit
  import cu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [2:0]       IR75,
  input  logic             Aeq0,
  input  logic             Apos,
  input  logic             enter,
  output logic             IRload,
  output logic             JMPmux,
  output logic             PCload,
  output logic             Meminst,
  output logic             MemWr,
  output logic [1:0]       Asel,
  output logic             Aload,
  output logic             Sub,
  output logic             input_req,
  output logic             halted,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= INIT;
    end else begin
      case (state)
        INIT:    state <= FETCH;
        FETCH:   state <= DECODE;
        DECODE: begin
          case (IR75)
            OP_LOAD:  state <= LOAD_X;
            OP_STORE: state <= STORE_X;
            OP_ADD:   state <= ADD_X;
            OP_SUB:   state <= SUB_X;
            OP_IN:    state <= IN_WAIT;
            OP_JZ:    state <= Aeq0 ? JUMP : FETCH;
            OP_JPOS:  state <= Apos ? JUMP : FETCH;
            OP_HALT:  state <= HALT;
            default:  state <= INIT;
          endcase
        end
        LOAD_X:  state <= FETCH;
        STORE_X: state <= FETCH;
        ADD_X:   state <= FETCH;
        SUB_X:   state <= FETCH;
        IN_WAIT: state <= enter ? IN_LOAD : IN_WAIT;
        IN_LOAD: state <= IN_REL;
        // Waiting for release keeps a long press from loading twice.
        IN_REL:  state <= enter ? IN_REL : FETCH;
        JUMP:    state <= FETCH;
        HALT:    state <= HALT;
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      instr_count <= '0;
    end else if (state == FETCH) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    IRload    = 1'b0;
    JMPmux    = 1'b0;
    PCload    = 1'b0;
    Meminst   = 1'b0;
    MemWr     = 1'b0;
    Asel      = ASEL_ALU;
    Aload     = 1'b0;
    Sub       = 1'b0;
    input_req = 1'b0;
    halted    = 1'b0;
    case (state)
      FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      DECODE: Meminst = 1'b1;
      LOAD_X: begin
        Meminst = 1'b1;
        Asel    = ASEL_RAM;
        Aload   = 1'b1;
      end
      STORE_X: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      ADD_X: begin
        Meminst = 1'b1;
        Asel    = ASEL_ALU;
        Aload   = 1'b1;
      end
      SUB_X: begin
        Meminst = 1'b1;
        Asel    = ASEL_ALU;
        Sub     = 1'b1;
        Aload   = 1'b1;
      end
      IN_WAIT: input_req = 1'b1;
      IN_LOAD: begin
        Asel  = ASEL_IN;
        Aload = 1'b1;
      end
      JUMP: begin
        JMPmux = 1'b1;
        PCload = 1'b1;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instructions plus a random program
// compared cycle by cycle against per-instruction expected strobe sequences.
module tb_control_unit;
  import cu_pkg::*;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [2:0] IR75 = 3'b000;
  logic       Aeq0 = 1'b0;
  logic       Apos = 1'b0;
  logic       enter = 1'b0;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, input_req, halted;
  logic [1:0] Asel;
  logic [3:0] state_out;
  logic [7:0] instr_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  control_unit #(.CNT_W(8)) dut (
    .clk(clk), .clear(clear), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos), .enter(enter),
    .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst),
    .MemWr(MemWr), .Asel(Asel), .Aload(Aload), .Sub(Sub), .input_req(input_req),
    .halted(halted), .state_out(state_out), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Strobe vector: {IRload,JMPmux,PCload,Meminst,MemWr,Asel[1:0],Aload,Sub,input_req,halted}
  function automatic logic [10:0] vec(logic irl, logic jm, logic pcl, logic mi, logic mw,
                                      logic [1:0] as, logic al, logic sb, logic rq, logic hl);
    return {irl, jm, pcl, mi, mw, as, al, sb, rq, hl};
  endfunction

  wire [10:0] outs = {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, input_req, halted};

  task automatic cyc(input string tag, input logic [10:0] e, input state_t s);
    checks++;
    assert (outs === e) else begin
      errors++;
      $error("FAIL %s strobes got %b exp %b", tag, outs, e);
    end
    checks++;
    assert (state_out === 4'(s)) else begin
      errors++;
      $error("FAIL %s state got %0d exp %0d", tag, state_out, 4'(s));
    end
    checks++;
    assert (instr_count === exp_cnt) else begin
      errors++;
      $error("FAIL %s count got %0d exp %0d", tag, instr_count, exp_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One whole instruction starting at its FETCH cycle; w = IN_WAIT cycles, h = extra held cycles.
  task automatic run_instr(input logic [2:0] op, input logic aeq, input logic apos,
                           input int w, input int h, input logic early);
    logic [10:0] v_zero, v_fetch, v_mem;
    v_zero  = vec(0,0,0,0,0,2'd0,0,0,0,0);
    v_fetch = vec(1,0,1,0,0,2'd0,0,0,0,0);
    v_mem   = vec(0,0,0,1,0,2'd0,0,0,0,0);
    cyc("fetch", v_fetch, FETCH);
    exp_cnt = exp_cnt + 8'd1;
    IR75 = op; Aeq0 = aeq; Apos = apos;
    enter = (op == OP_IN) && early;
    tick();
    cyc("decode", v_mem, DECODE);
    tick();
    IR75 = 3'($urandom);
    case (op)
      OP_LOAD:  begin cyc("load_x", vec(0,0,0,1,0,2'd2,1,0,0,0), LOAD_X); tick(); end
      OP_STORE: begin cyc("store_x", vec(0,0,0,1,1,2'd0,0,0,0,0), STORE_X); tick(); end
      OP_ADD:   begin cyc("add_x", vec(0,0,0,1,0,2'd0,1,0,0,0), ADD_X); tick(); end
      OP_SUB:   begin cyc("sub_x", vec(0,0,0,1,0,2'd0,1,1,0,0), SUB_X); tick(); end
      OP_JZ, OP_JPOS: begin
        if ((op == OP_JZ && aeq) || (op == OP_JPOS && apos)) begin
          cyc("jump", vec(0,1,1,0,0,2'd0,0,0,0,0), JUMP);
          tick();
        end
      end
      OP_IN: begin
        for (int i = 0; i < w; i++) begin
          if (i == w - 1) enter = 1'b1;
          cyc("in_wait", vec(0,0,0,0,0,2'd0,0,0,1,0), IN_WAIT);
          tick();
        end
        cyc("in_load", vec(0,0,0,0,0,2'd1,1,0,0,0), IN_LOAD);
        tick();
        for (int i = 0; i < h; i++) begin
          cyc("in_rel_held", v_zero, IN_REL);
          tick();
        end
        enter = 1'b0;
        cyc("in_rel", v_zero, IN_REL);
        tick();
      end
      default: begin
        for (int i = 0; i < 20; i++) begin
          cyc("halt", vec(0,0,0,0,0,2'd0,0,0,0,1), HALT);
          tick();
        end
      end
    endcase
  endtask

  initial begin
    logic [2:0] op;
    int w;
    logic early;

    // Reset state while clear is held, then release: one INIT cycle, then FETCH.
    @(negedge clk);
    cyc("reset_hold", 11'd0, INIT);
    clear = 1'b0;
    tick();

    // Directed instructions from the test plan.
    run_instr(OP_LOAD, 0, 0, 1, 0, 0);
    run_instr(OP_SUB, 0, 1, 1, 0, 0);
    run_instr(OP_STORE, 1, 0, 1, 0, 0);
    run_instr(OP_JZ, 1, 0, 1, 0, 0);
    run_instr(OP_JZ, 0, 1, 1, 0, 0);
    run_instr(OP_JPOS, 0, 1, 1, 0, 0);
    run_instr(OP_JPOS, 1, 0, 1, 0, 0);
    run_instr(OP_IN, 0, 0, 6, 2, 0);
    run_instr(OP_IN, 0, 0, 1, 0, 1);
    run_instr(OP_ADD, 0, 0, 1, 0, 0);

    // Random program long enough to wrap the 8-bit fetch counter.
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 6));
      early = 1'($urandom);
      w = early ? 1 : $urandom_range(1, 4);
      run_instr(op, 1'($urandom), 1'($urandom), w, $urandom_range(0, 3), early);
    end
    $display("random program done, fetches modulo 256 = %0d", exp_cnt);

    // Abort in the middle of ADD_X: outputs clear asynchronously, before any edge.
    cyc("fetch_pre_abort", vec(1,0,1,0,0,2'd0,0,0,0,0), FETCH);
    exp_cnt = exp_cnt + 8'd1;
    IR75 = OP_ADD;
    tick();
    cyc("decode_pre_abort", vec(0,0,0,1,0,2'd0,0,0,0,0), DECODE);
    tick();
    cyc("add_pre_abort", vec(0,0,0,1,0,2'd0,1,0,0,0), ADD_X);
    #1 clear = 1'b1;
    #1 exp_cnt = 8'd0;
    cyc("abort_async", 11'd0, INIT);
    @(negedge clk);
    clear = 1'b0;
    tick();

    // Wrap boundary: 256 fetches from zero bring the counter back to zero.
    for (int n = 0; n < 256; n++) run_instr(OP_JZ, 0, 0, 1, 0, 0);
    checks++;
    assert (instr_count === 8'd0) else begin
      errors++;
      $error("FAIL wrap count got %0d exp 0", instr_count);
    end

    run_instr(OP_HALT, 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Finite-state controller that sits directly upstream of the 8-bit processor datapath.
- Consumes the opcode field IR75 and the accumulator flags Aeq0/Apos from the datapath.
- Drives every datapath control strobe to execute the 8-instruction set: fetch, decode, execute.
- Also provides a handshake for the IN instruction, a halt indication and a retired-instruction counter for debug.

Parameters:
- CNT_W, 8, width of the instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous, active-high reset.
- IR75  input  3  opcode, IR[7:5], from the datapath.
- Aeq0  input  1  accumulator == 0 flag.
- Apos  input  1  accumulator > 0 flag (sign clear and nonzero).
- enter  input  1  operator-input strobe for the IN instruction, level-sensitive.
- IRload  output  1  load instruction register.
- JMPmux  output  1  PC source select: 0 = PC+1, 1 = IR[4:0].
- PCload  output  1  load PC.
- Meminst  output  1  memory address select: 0 = PC, 1 = IR[4:0].
- MemWr  output  1  RAM write enable.
- Asel  output  2  A-input mux: 0 = ALU (A±RAM), 1 = in, 2 = RAM, 3 = zero.
- Aload  output  1  load accumulator.
- Sub  output  1  ALU subtract (1) / add (0).
- input_req  output  1  high while waiting for operator input.
- halted  output  1  high in HALT state.
- state_out  output  4  current state encoding (debug).
- instr_count  output  CNT_W  number of instructions fetched, wrapping.

Behaviour:
- Single clock; clear is asynchronous and active-high.
- clear forces state = INIT and instr_count = 0. All outputs are 0 while in INIT.
- All control outputs are Moore: combinational decode of the state register only. There is no Mealy path from the inputs.
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 IN, 101 JZ, 110 JPOS, 111 HALT.
- State actions and transitions (outputs not listed are 0):
  - INIT: no strobes. Next state is FETCH unconditionally.
  - FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0. instr_count increments on every cycle spent in FETCH. Next state is DECODE.
  - DECODE: Meminst=1. Branches on IR75:
    - LOAD→LOAD_X, STORE→STORE_X, ADD→ADD_X, SUB→SUB_X.
    - IN→IN_WAIT.
    - JZ→JUMP if Aeq0, else FETCH.
    - JPOS→JUMP if Apos, else FETCH.
    - HALT→HALT.
  - LOAD_X: Meminst=1, Asel=2, Aload=1. Next state is FETCH.
  - STORE_X: Meminst=1, MemWr=1. Next state is FETCH.
  - ADD_X: Meminst=1, Asel=0, Sub=0, Aload=1. Next state is FETCH.
  - SUB_X: Meminst=1, Asel=0, Sub=1, Aload=1. Next state is FETCH.
  - IN_WAIT: input_req=1. Stays until enter=1, then goes to IN_LOAD.
  - IN_LOAD: Asel=1, Aload=1. Next state is IN_REL.
  - IN_REL: stays until enter=0, then goes to FETCH. One enter press loads exactly once.
  - JUMP: JMPmux=1, PCload=1. Next state is FETCH.
  - HALT: halted=1. Stays here until clear.
- Latency in cycles, FETCH through the last execute state:
  - LOAD/STORE/ADD/SUB: 3.
  - JZ/JPOS taken: 3; not taken: 2.
  - IN: 3 + wait cycles + release cycles.
- Flags are sampled in DECODE only. They reflect A as loaded by the previous instruction.
- enter already high on arrival in IN_WAIT is accepted on that cycle's edge (IN_LOAD follows next cycle).
- instr_count wraps 2^CNT_W−1 → 0. It is frozen in HALT and in the IN wait states.
- clear asserted mid-instruction aborts immediately to INIT. No partial strobe survives, because outputs decode from state.
- Illegal state encodings go to INIT on the next clock.

Decomposition:
- Shared package cu_pkg holds:
  - opcode constants (OP_LOAD..OP_HALT);
  - the state enumeration, 4-bit encoding with INIT = 0;
  - Asel codes (ASEL_ALU=0, ASEL_IN=1, ASEL_RAM=2, ASEL_ZERO=3).
- Single module. The instruction counter is inline, with no sub-module.

Test Plan:
- Reset: assert clear mid-ADD_X → all outputs 0 and state_out=INIT immediately; FETCH one cycle after release; instr_count=0.
- LOAD (IR75=000) → FETCH strobes IRload=PCload=1; DECODE Meminst=1; next cycle Asel=2, Aload=1; back to FETCH on cycle 4; instr_count=1.
- SUB (IR75=011) → execute cycle shows Asel=0, Sub=1, Aload=1, Meminst=1. STORE (001) → MemWr=1 for exactly one cycle.
- JZ with Aeq0=1 → JUMP cycle JMPmux=1, PCload=1. JZ with Aeq0=0 → DECODE then FETCH, 2 cycles, no JMPmux.
- IN: hold enter=0 for 5 cycles (input_req=1, instr_count steady), then enter=1 for 4 cycles → Aload with Asel=1 exactly once; FETCH only after enter returns to 0.
- HALT (111) → halted=1 held for 20 cycles with all strobes 0. Wrap: 256 fetches with CNT_W=8 → instr_count returns to 0.
